// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
// Shares one single-port synchronous Data RAM between the EXE-stage
// load/store port (port 0) and a secondary master such as DMA or debug
// (port 1). At most one access is issued per cycle. Read data is steered
// back to the port that issued the read, and each port keeps its last
// read data until its next read completes.

module data_ram_arbiter #(
    parameter int FIXED_PRIO = 0,  // 1: port 0 wins conflicts; 0: round-robin
    parameter int STARVE_MAX = 4   // fixed-priority only: losses before port 1 wins (0 = never)
) (
    input  logic        clk,
    input  logic        resetn,

    // Port 0: EXE-stage load/store
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    // Port 1: secondary master
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    // Data RAM macro
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    // The starvation counter must be able to hold STARVE_MAX itself.
    localparam int               CNT_W      = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // Arbitration state
    logic             r_rr_ptr;      // 0: port 0 preferred, 1: port 1 preferred
    logic [CNT_W-1:0] r_starve_cnt;  // consecutive conflict losses of port 1

    // Read-return tracking: a read issued in stage p0 returns in stage p1
    logic             r_m0_rd_p1;
    logic             r_m1_rd_p1;
    logic [31:0]      r_m0_rdata_p1;
    logic [31:0]      r_m1_rdata_p1;

    // Combinational arbitration results
    logic             w_conflict;
    logic             w_pick1;
    logic             w_m0_gnt;
    logic             w_m1_gnt;
    logic             w_m0_is_rd;
    logic             w_m1_is_rd;

    // Decide which port wins when both request in the same cycle.
    always_comb begin
        w_conflict = m0_req & m1_req;
        w_pick1    = 1'b0;
        if (FIXED_PRIO != 0) begin
            w_pick1 = (STARVE_MAX != 0) && (r_starve_cnt == STARVE_LIM);
        end else begin
            w_pick1 = r_rr_ptr;
        end
        // Grants are suppressed while reset is asserted so the RAM is never
        // touched during reset even if a requester is still active.
        w_m0_gnt   = resetn & m0_req & ~(m1_req &  w_pick1);
        w_m1_gnt   = resetn & m1_req & ~(m0_req & ~w_pick1);
        w_m0_is_rd = (m0_we == 4'b0000);
        w_m1_is_rd = (m1_we == 4'b0000);
    end

    // Steer the granted port onto the RAM; drive zeros when idle.
    always_comb begin
        ram_en    = w_m0_gnt | w_m1_gnt;
        ram_we    = 4'b0000;
        ram_addr  = 32'h0000_0000;
        ram_wdata = 32'h0000_0000;
        if (w_m0_gnt) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (w_m1_gnt) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    // Round-robin pointer moves only on a conflict and points at the loser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= 1'b0;
        end else if (w_conflict) begin
            r_rr_ptr <= w_m0_gnt;
        end
    end

    // Count port 1 conflict losses, saturating; a port 1 grant clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (w_m1_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_conflict && w_m0_gnt && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // ---- stage p0 -> p1: remember which port owns the read in flight ----
    // Reset drops any in-flight response so no rvalid appears afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m0_rd_p1 <= 1'b0;
            r_m1_rd_p1 <= 1'b0;
        end else begin
            r_m0_rd_p1 <= w_m0_gnt & w_m0_is_rd;
            r_m1_rd_p1 <= w_m1_gnt & w_m1_is_rd;
        end
    end

    // ---- stage p1: capture returning read data into the owner's holding register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m0_rdata_p1 <= 32'h0000_0000;
            r_m1_rdata_p1 <= 32'h0000_0000;
        end else begin
            if (r_m0_rd_p1) begin
                r_m0_rdata_p1 <= ram_rdata;
            end
            if (r_m1_rd_p1) begin
                r_m1_rdata_p1 <= ram_rdata;
            end
        end
    end

    // Read data is presented straight from the RAM in the return cycle and
    // from the holding register afterwards, so rdata is valid with rvalid.
    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign m0_rvalid = r_m0_rd_p1;
    assign m1_rvalid = r_m1_rd_p1;
    assign m0_rdata  = r_m0_rd_p1 ? ram_rdata : r_m0_rdata_p1;
    assign m1_rdata  = r_m1_rd_p1 ? ram_rdata : r_m1_rdata_p1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: one round-robin instance and one
// fixed-priority instance (STARVE_MAX=4) share the same requester stimulus,
// each backed by its own behavioural synchronous RAM.

module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;

    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

    // Round-robin instance signals
    logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_ram_en;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_ram_addr, rr_ram_wdata;
    logic [31:0] rr_ram_rdata = 32'h0;
    logic [3:0]  rr_ram_we;

    // Fixed-priority instance signals
    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_ram_en;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_ram_addr, fp_ram_wdata;
    logic [31:0] fp_ram_rdata = 32'h0;
    logic [3:0]  fp_ram_we;

    logic [31:0] rr_mem [0:255];
    logic [31:0] fp_mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    bit exp_rr [0:5];
    bit exp_fp [0:5];

    always #5 clk = ~clk;

    data_ram_arbiter #(.FIXED_PRIO(0), .STARVE_MAX(4)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
        .ram_en(rr_ram_en), .ram_we(rr_ram_we), .ram_addr(rr_ram_addr),
        .ram_wdata(rr_ram_wdata), .ram_rdata(rr_ram_rdata)
    );

    data_ram_arbiter #(.FIXED_PRIO(1), .STARVE_MAX(4)) u_fp (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_addr(fp_ram_addr),
        .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
    );

    // Synchronous word RAM for the round-robin instance
    always @(posedge clk) begin
        if (rr_ram_en) begin
            if (rr_ram_we == 4'b0000) rr_ram_rdata <= rr_mem[rr_ram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (rr_ram_we[b]) rr_mem[rr_ram_addr[9:2]][8*b +: 8] <= rr_ram_wdata[8*b +: 8];
        end
    end

    // Synchronous word RAM for the fixed-priority instance
    always @(posedge clk) begin
        if (fp_ram_en) begin
            if (fp_ram_we == 4'b0000) fp_ram_rdata <= fp_mem[fp_ram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (fp_ram_we[b]) fp_mem[fp_ram_addr[9:2]][8*b +: 8] <= fp_ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rr_mem[i] = 32'hC0DE_0000 | i;
            fp_mem[i] = 32'hC0DE_0000 | i;
        end
        rr_mem[8'h40] = 32'hDEAD_BEEF;
        fp_mem[8'h40] = 32'hDEAD_BEEF;
        exp_rr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_fp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset with port 0 requesting: nothing may be granted or issued
        resetn = 1'b0;
        set_m0(1'b1, 4'b0000, 32'h100, 32'h0);
        set_m1(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rr_m0_gnt",    rr_m0_gnt,    0);
        chk("rst_rr_m1_gnt",    rr_m1_gnt,    0);
        chk("rst_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("rst_rr_m1_rvalid", rr_m1_rvalid, 0);
        chk("rst_rr_m0_rdata",  rr_m0_rdata,  0);
        chk("rst_rr_m1_rdata",  rr_m1_rdata,  0);
        chk("rst_rr_ram_en",    rr_ram_en,    0);
        chk("rst_rr_ram_we",    rr_ram_we,    0);
        chk("rst_fp_m0_gnt",    fp_m0_gnt,    0);
        chk("rst_fp_ram_en",    fp_ram_en,    0);

        @(negedge clk);
        resetn = 1'b1;
        set_m0(1'b0, 4'b0000, 32'h0, 32'h0);

        // Port 0 alone reads 0x100
        @(negedge clk);
        set_m0(1'b1, 4'b0000, 32'h100, 32'h0);
        #1;
        chk("rd0_rr_m0_gnt",   rr_m0_gnt,   1);
        chk("rd0_rr_m1_gnt",   rr_m1_gnt,   0);
        chk("rd0_rr_ram_en",   rr_ram_en,   1);
        chk("rd0_rr_ram_addr", rr_ram_addr, 32'h100);
        chk("rd0_rr_ram_we",   rr_ram_we,   0);
        chk("rd0_fp_m0_gnt",   fp_m0_gnt,   1);

        @(negedge clk);
        set_m0(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("rd0_rr_m0_rvalid", rr_m0_rvalid, 1);
        chk("rd0_rr_m0_rdata",  rr_m0_rdata,  32'hDEAD_BEEF);
        chk("rd0_rr_m1_rvalid", rr_m1_rvalid, 0);
        chk("rd0_rr_m1_rdata",  rr_m1_rdata,  0);
        chk("rd0_fp_m0_rdata",  fp_m0_rdata,  32'hDEAD_BEEF);

        @(negedge clk);
        #1;
        chk("hold_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("hold_rr_m0_rdata",  rr_m0_rdata,  32'hDEAD_BEEF);
        chk("idle_rr_ram_en",    rr_ram_en,    0);
        chk("idle_rr_ram_addr",  rr_ram_addr,  0);

        // Both ports read continuously: port 0 at 0x000, port 1 at 0x004
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_m0(1'b1, 4'b0000, 32'h000, 32'h0);
            set_m1(1'b1, 4'b0000, 32'h004, 32'h0);
            #1;
            chk("cf_rr_m0_gnt", rr_m0_gnt, exp_rr[k]);
            chk("cf_rr_m1_gnt", rr_m1_gnt, !exp_rr[k]);
            chk("cf_fp_m0_gnt", fp_m0_gnt, exp_fp[k]);
            chk("cf_fp_m1_gnt", fp_m1_gnt, !exp_fp[k]);
            if (k > 0) begin
                chk("cf_rr_m0_rvalid", rr_m0_rvalid, exp_rr[k-1]);
                chk("cf_rr_m1_rvalid", rr_m1_rvalid, !exp_rr[k-1]);
                chk("cf_fp_m1_rvalid", fp_m1_rvalid, !exp_fp[k-1]);
                if (exp_rr[k-1]) chk("cf_rr_m0_rdata", rr_m0_rdata, 32'hC0DE_0000);
                else             chk("cf_rr_m1_rdata", rr_m1_rdata, 32'hC0DE_0001);
            end
        end

        @(negedge clk);
        set_m0(1'b0, 4'b0000, 32'h0, 32'h0);
        set_m1(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("cf_end_rr_m1_rvalid", rr_m1_rvalid, 1);
        chk("cf_end_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("cf_end_fp_m0_rvalid", fp_m0_rvalid, 1);
        chk("cf_end_fp_m1_rdata",  fp_m1_rdata,  32'hC0DE_0001);

        // Port 1 byte write to 0x201
        @(negedge clk);
        set_m1(1'b1, 4'b0010, 32'h201, 32'h0000_AB00);
        #1;
        chk("wr1_rr_m1_gnt",    rr_m1_gnt,    1);
        chk("wr1_rr_ram_en",    rr_ram_en,    1);
        chk("wr1_rr_ram_we",    rr_ram_we,    4'b0010);
        chk("wr1_rr_ram_addr",  rr_ram_addr,  32'h201);
        chk("wr1_rr_ram_wdata", rr_ram_wdata, 32'h0000_AB00);

        @(negedge clk);
        set_m1(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("wr1_rr_m1_rvalid", rr_m1_rvalid, 0);
        chk("wr1_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("wr1_rr_m1_rdata",  rr_m1_rdata,  32'hC0DE_0001);

        // Port 0 read at N, port 1 write at N+1, port 1 read-back at N+2
        @(negedge clk);
        set_m0(1'b1, 4'b0000, 32'h200, 32'h0);
        #1;
        chk("rw_rr_m0_gnt", rr_m0_gnt, 1);

        @(negedge clk);
        set_m0(1'b0, 4'b0000, 32'h0, 32'h0);
        set_m1(1'b1, 4'b1111, 32'h00C, 32'h1234_5678);
        #1;
        chk("rw_rr_m1_gnt",    rr_m1_gnt,    1);
        chk("rw_rr_ram_we",    rr_ram_we,    4'b1111);
        chk("rw_rr_m0_rvalid", rr_m0_rvalid, 1);
        chk("rw_rr_m0_rdata",  rr_m0_rdata,  32'hC0DE_AB80);
        chk("rw_fp_m0_rdata",  fp_m0_rdata,  32'hC0DE_AB80);

        @(negedge clk);
        set_m1(1'b1, 4'b0000, 32'h00C, 32'h0);
        #1;
        chk("rb_rr_m1_gnt",    rr_m1_gnt,    1);
        chk("rb_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("rb_rr_m1_rvalid", rr_m1_rvalid, 0);

        @(negedge clk);
        set_m1(1'b0, 4'b0000, 32'h0, 32'h0);
        #1;
        chk("rb_rr_m1_rvalid", rr_m1_rvalid, 1);
        chk("rb_rr_m1_rdata",  rr_m1_rdata,  32'h1234_5678);
        chk("rb_rr_m0_rdata",  rr_m0_rdata,  32'hC0DE_AB80);

        // Reset asserted while a read is being requested
        @(negedge clk);
        set_m0(1'b1, 4'b0000, 32'h100, 32'h0);
        #1;
        chk("mr_rr_m0_gnt", rr_m0_gnt, 1);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("mr_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("mr_rr_m0_rdata",  rr_m0_rdata,  0);
        chk("mr_rr_m1_rdata",  rr_m1_rdata,  0);
        chk("mr_rr_m0_gnt2",   rr_m0_gnt,    0);
        chk("mr_rr_ram_en",    rr_ram_en,    0);
        chk("mr_fp_m0_rvalid", fp_m0_rvalid, 0);

        @(negedge clk);
        set_m0(1'b0, 4'b0000, 32'h0, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_post_rr_m0_rvalid", rr_m0_rvalid, 0);
        chk("mr_post_rr_m0_rdata",  rr_m0_rdata,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
